weight_bias_loader: RTL and testbench

Configuration master that writes the per-neuron weight memories and bias registers of the fully connected network. Accepts a 32-bit record stream from the host/DMA side using a valid/ready handshake, decodes each record header and replays its payload onto the shared neuron configuration bus (`weightValid`, `biasValid`, `weightValue`, `biasValue`, `config_layer_num`, `config_neuron_num`). Sits between the host interface and every neuron instance. It is the writer for the neurons' weight-load port.

---
 rtl/weight_bias_loader.sv | 215 +++++++++++++++++++++
 tb/tb_weight_bias_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bias_loader.sv
// weight_bias_loader
// Configuration master for the fully connected network. It takes a 32-bit
// record stream (header, N weight words, optional bias word) over a
// valid/ready handshake. It replays the payload onto the shared neuron
// configuration bus as one-cycle strobes.
//
// Optional feature: define LOADER_BIAS_EN to expect a bias word after the
// weights of each record. Without it, a record ends on its Nth weight, and
// biasValid/biasValue are tied to 0.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   s_data/s_valid/s_ready record stream input
//   weightValid/weightValue  weight strobe and registered weight word
//   biasValid/biasValue      bias strobe and registered bias word
//   config_layer_num/config_neuron_num  target of current/last record
//   busy        record in progress (header accepted .. final strobe)
//   load_done   pulse with the final strobe of a record flagged last
//   err         sticky header error; loader stops accepting until rst
//   rec_count   records completed since reset (wraps)
//
// state | meaning
// HDR   | waiting for / decoding a record header
// WGT   | replaying weight words, counter holds weights remaining
// BIAS  | expecting the bias word (LOADER_BIAS_EN only)
// ERR   | bad header seen, stream stalled until rst
module weight_bias_loader #(
   parameter int numLayers  = 4,
   parameter int maxNeurons = 30,
   parameter int maxWeights = 784
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        weightValid,
   output logic        biasValid,
   output logic [31:0] weightValue,
   output logic [31:0] biasValue,
   output logic [31:0] config_layer_num,
   output logic [31:0] config_neuron_num,
   output logic        busy,
   output logic        load_done,
   output logic        err,
   output logic [15:0] rec_count
);

   localparam logic [6:0]  MAX_LAYER  = 7'(numLayers);
   localparam logic [7:0]  NEURON_LIM = 8'(maxNeurons);
   localparam logic [15:0] MAX_WGT    = 16'(maxWeights);

`ifdef LOADER_BIAS_EN
   typedef enum logic [1:0] {ST_HDR = 2'd0, ST_WGT = 2'd1, ST_BIAS = 2'd2, ST_ERR = 2'd3} state_t;
`else
   typedef enum logic [1:0] {ST_HDR = 2'd0, ST_WGT = 2'd1, ST_ERR = 2'd3} state_t;
`endif

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        wv_q, wv_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] layer_q, layer_d;
   logic [31:0] neuron_q, neuron_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] rec_q, rec_d;
`ifdef LOADER_BIAS_EN
   logic        bv_q, bv_d;
   logic [31:0] bdata_q, bdata_d;
`endif

   logic        acc;
   logic        rec_end;
   logic [6:0]  hdr_layer;
   logic [7:0]  hdr_neuron;
   logic [15:0] hdr_n;
   logic        hdr_bad;

   assign hdr_layer  = s_data[30:24];
   assign hdr_neuron = s_data[23:16];
   assign hdr_n      = s_data[15:0];
   assign hdr_bad    = (hdr_layer == 7'd0) || (hdr_layer > MAX_LAYER) ||
                       (hdr_neuron >= NEURON_LIM) ||
                       (hdr_n == 16'd0) || (hdr_n > MAX_WGT);

   // Ready is forced low in the reset cycle itself, hence combinational.
   assign s_ready = ~rst & (state_q != ST_ERR);
   assign acc     = s_valid & s_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      wv_d     = 1'b0;
      wdata_d  = wdata_q;
      layer_d  = layer_q;
      neuron_d = neuron_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = err_q;
      rec_d    = rec_q;
      rec_end  = 1'b0;
`ifdef LOADER_BIAS_EN
      bv_d     = 1'b0;
      bdata_d  = bdata_q;
`endif
      case (state_q)
         ST_HDR: begin
            if (acc) begin
               if (hdr_bad) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d  = ST_WGT;
                  last_d   = s_data[31];
                  cnt_d    = hdr_n;
                  layer_d  = {25'd0, hdr_layer};
                  neuron_d = {24'd0, hdr_neuron};
                  busy_d   = 1'b1;
               end
            end
         end
         ST_WGT: begin
            // busy covers the strobe cycle of the final word as well
            busy_d = 1'b1;
            if (acc) begin
               wv_d    = 1'b1;
               wdata_d = s_data;
               cnt_d   = cnt_q - 16'd1;
               if (cnt_q == 16'd1) begin
`ifdef LOADER_BIAS_EN
                  state_d = ST_BIAS;
`else
                  state_d = ST_HDR;
                  rec_end = 1'b1;
`endif
               end
            end
         end
`ifdef LOADER_BIAS_EN
         ST_BIAS: begin
            busy_d = 1'b1;
            if (acc) begin
               bv_d    = 1'b1;
               bdata_d = s_data;
               state_d = ST_HDR;
               rec_end = 1'b1;
            end
         end
`endif
         ST_ERR: err_d = 1'b1;
         default: state_d = ST_HDR;
      endcase
      if (rec_end) begin
         rec_d  = rec_q + 16'd1;
         done_d = last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_HDR;
         cnt_q    <= '0;
         last_q   <= 1'b0;
         wv_q     <= 1'b0;
         wdata_q  <= '0;
         layer_q  <= '0;
         neuron_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rec_q    <= '0;
`ifdef LOADER_BIAS_EN
         bv_q     <= 1'b0;
         bdata_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         wv_q     <= wv_d;
         wdata_q  <= wdata_d;
         layer_q  <= layer_d;
         neuron_q <= neuron_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rec_q    <= rec_d;
`ifdef LOADER_BIAS_EN
         bv_q     <= bv_d;
         bdata_q  <= bdata_d;
`endif
      end
   end

   assign weightValid       = wv_q;
   assign weightValue       = wdata_q;
   assign config_layer_num  = layer_q;
   assign config_neuron_num = neuron_q;
   assign busy              = busy_q;
   assign load_done         = done_q;
   assign err               = err_q;
   assign rec_count         = rec_q;
`ifdef LOADER_BIAS_EN
   assign biasValid         = bv_q;
   assign biasValue         = bdata_q;
`else
   assign biasValid         = 1'b0;
   assign biasValue         = 32'd0;
`endif

endmodule

// File: tb/tb_weight_bias_loader.sv
// Self-checking bench for weight_bias_loader. It covers directed header
// checks, multi-cycle corner sequences and a randomized record stream
// compared against an expected event list built from the record format.
module tb_weight_bias_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        weightValid, biasValid;
   logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;
   logic        busy, load_done, err;
   logic [15:0] rec_count;

`ifdef LOADER_BIAS_EN
   localparam bit BIAS_EN = 1'b1;
`else
   localparam bit BIAS_EN = 1'b0;
`endif

   weight_bias_loader dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .weightValid(weightValid), .biasValid(biasValid),
      .weightValue(weightValue), .biasValue(biasValue),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .busy(busy), .load_done(load_done), .err(err), .rec_count(rec_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int stalls  = 0;
   int done_cnt = 0;
   logic [95:0] obs_w[$], obs_b[$], exp_w[$], exp_b[$];

   // strobe observer: each event tagged with the target it was sent to
   always @(negedge clk) begin
      if (weightValid) obs_w.push_back({config_layer_num, config_neuron_num, weightValue});
      if (biasValid)   obs_b.push_back({config_layer_num, config_neuron_num, biasValue});
      if (load_done)   done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] hdr(input bit last, input int layer, input int neuron, input int n);
      return {last, 7'(layer), 8'(neuron), 16'(n)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word and return in the cycle after it is accepted.
   task automatic put(input logic [31:0] w);
      int guard;
      guard = 0;
      s_data  = w;
      s_valid = 1'b1;
      while (!s_ready && guard < 20) begin
         tick();
         guard++;
         stalls++;
      end
      if (guard >= 20) begin
         n_tests++;
         n_fail++;
         $display("FAIL put_timeout: got s_ready=0 for 20 cycles required 1");
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_valid = 1'b0;
      s_data = '0;
      tick();
      rst = 1'b0;
      obs_w.delete();
      obs_b.delete();
      done_cnt = 0;
      stalls = 0;
      #1;
   endtask

   // Header decode table
   typedef struct {
      string       name;
      logic [31:0] h;
      bit          bad;
      logic [31:0] lay;
      logic [31:0] neu;
   } hv_t;
   hv_t hv[7];

   // Single record {last=1, layer 4, neuron 7, N=3}, optional 2-cycle gap
   task automatic rec_test(input bit gap);
      logic [31:0] ws[3];
      ws[0] = 32'h11; ws[1] = 32'h22; ws[2] = 32'h33;
      do_reset();
      put(hdr(1, 4, 7, 3));
      check("t1_cfg_layer", config_layer_num, 32'd4);
      check("t1_cfg_neuron", config_neuron_num, 32'd7);
      check("t1_hdr_no_strobe", weightValid, 1'b0);
      check("t1_busy_hdr", busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         put(ws[i]);
         check("t1_wvalid", weightValid, 1'b1);
         check("t1_wvalue", weightValue, ws[i]);
         check("t1_busy_w", busy, 1'b1);
         check("t1_done_w", load_done, (i == 2) && !BIAS_EN);
         if (gap && i == 0) begin
            for (int g = 0; g < 2; g++) begin
               idle(1);
               check("t2_gap_no_strobe", weightValid, 1'b0);
               check("t2_gap_busy", busy, 1'b1);
               check("t2_gap_hold", weightValue, 32'h11);
            end
         end
      end
`ifdef LOADER_BIAS_EN
      put(32'hC96A);
      check("t1_bvalid", biasValid, 1'b1);
      check("t1_bvalue", biasValue, 32'hC96A);
      check("t1_done_b", load_done, 1'b1);
      check("t1_no_w_at_b", weightValid, 1'b0);
`endif
      check("t1_rec_count", rec_count, 16'd1);
      idle(1);
      check("t1_idle_busy", busy, 1'b0);
      check("t1_idle_done", load_done, 1'b0);
      check("t1_hold_w", weightValue, 32'h33);
      check("t1_hold_cfg", config_layer_num, 32'd4);
      check("t1_done_cnt", done_cnt, 1);
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      tick();
      check("rst_s_ready_low", s_ready, 1'b0);
      check("rst_outputs_a", {weightValid, biasValid, busy, load_done, err, rec_count}, '0);
      check("rst_outputs_b", {weightValue, biasValue, config_layer_num, config_neuron_num}, '0);
      rst = 1'b0;
      #1;
      check("rst_s_ready_after", s_ready, 1'b1);

      // header decode table
      hv[0] = '{"n_zero",     hdr(0, 1, 0, 0),    1'b1, 32'd0, 32'd0};
      hv[1] = '{"n_785",      hdr(0, 1, 0, 785),  1'b1, 32'd0, 32'd0};
      hv[2] = '{"layer_5",    hdr(0, 5, 0, 1),    1'b1, 32'd0, 32'd0};
      hv[3] = '{"neuron_30",  hdr(0, 1, 30, 1),   1'b1, 32'd0, 32'd0};
      hv[4] = '{"layer_0",    hdr(0, 0, 0, 1),    1'b1, 32'd0, 32'd0};
      hv[5] = '{"n_784_ok",   hdr(0, 4, 29, 784), 1'b0, 32'd4, 32'd29};
      hv[6] = '{"min_ok",     hdr(1, 1, 0, 1),    1'b0, 32'd1, 32'd0};
      for (int i = 0; i < 7; i++) begin
         do_reset();
         put(hv[i].h);
         check({hv[i].name, "_err"}, err, hv[i].bad);
         check({hv[i].name, "_ready"}, s_ready, !hv[i].bad);
         check({hv[i].name, "_busy"}, busy, !hv[i].bad);
         check({hv[i].name, "_cfg_layer"}, config_layer_num, hv[i].lay);
         check({hv[i].name, "_cfg_neuron"}, config_neuron_num, hv[i].neu);
         if (hv[i].bad) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            tick();
            tick();
            s_valid = 1'b0;
            tick();
            check({hv[i].name, "_no_strobes"}, obs_w.size() + obs_b.size(), 0);
            check({hv[i].name, "_err_sticky"}, err, 1'b1);
            check({hv[i].name, "_cfg_zero"}, config_layer_num | config_neuron_num, 32'd0);
         end
      end

      rec_test(1'b0);
      rec_test(1'b1);

      // back-to-back records
      do_reset();
      put(hdr(0, 1, 0, 2));
      put(32'hA1);
      check("b2b_w1", weightValue, 32'hA1);
      put(32'hA2);
      check("b2b_w2_valid", weightValid, 1'b1);
      check("b2b_w2_done", load_done, 1'b0);
`ifdef LOADER_BIAS_EN
      put(32'hB1);
      check("b2b_b1", biasValue, 32'hB1);
`endif
      check("b2b_rec1", rec_count, 16'd1);
      put(hdr(1, 1, 1, 1));
      check("b2b_hdr2_busy", busy, 1'b1);
      check("b2b_hdr2_neuron", config_neuron_num, 32'd1);
      put(32'hA3);
      check("b2b_w3", weightValue, 32'hA3);
`ifdef LOADER_BIAS_EN
      put(32'hB2);
      check("b2b_b2", biasValue, 32'hB2);
`endif
      check("b2b_done", load_done, 1'b1);
      check("b2b_rec2", rec_count, 16'd2);
      idle(1);
      check("b2b_done_cnt", done_cnt, 1);
      check("b2b_stalls", stalls, 0);
      check("b2b_busy_end", busy, 1'b0);

      // reset in the middle of a record
      do_reset();
      put(hdr(0, 2, 3, 5));
      put(32'h1);
      put(32'h2);
      rst = 1'b1;
      s_valid = 1'b1;
      s_data = 32'h3;
      #1;
      check("mid_rst_ready", s_ready, 1'b0);
      @(posedge clk);
      #1;
      check("mid_rst_out_a", {weightValid, biasValid, busy, load_done, err, rec_count}, '0);
      check("mid_rst_out_b", {weightValue, biasValue, config_layer_num, config_neuron_num}, '0);
      rst = 1'b0;
      s_valid = 1'b0;
      obs_w.delete();
      obs_b.delete();
      done_cnt = 0;
      #1;
      check("mid_rst_ready_after", s_ready, 1'b1);
      idle(3);
      check("mid_rst_no_strobes", obs_w.size() + obs_b.size(), 0);
      put(hdr(1, 3, 4, 1));
      put(32'h77);
`ifdef LOADER_BIAS_EN
      put(32'h88);
`endif
      check("mid_rst_fresh_done", load_done, 1'b1);
      check("mid_rst_fresh_rec", rec_count, 16'd1);
      idle(1);
      check("mid_rst_fresh_cnt", obs_w.size(), 1);
      check("mid_rst_fresh_evt", obs_w[0], {32'd3, 32'd4, 32'h77});

`ifndef LOADER_BIAS_EN
      // without bias, word N+1 is the next header
      do_reset();
      put(hdr(0, 1, 3, 2));
      put(32'hC1);
      put(32'hC2);
      check("nb_rec1", rec_count, 16'd1);
      put(hdr(1, 2, 5, 1));
      check("nb_hdr2_layer", config_layer_num, 32'd2);
      check("nb_hdr2_err", err, 1'b0);
      put(32'hC3);
      check("nb_done", load_done, 1'b1);
      check("nb_rec2", rec_count, 16'd2);
      idle(1);
      check("nb_no_bias", obs_b.size(), 0);
`endif

      // randomized record stream against expected event list
      do_reset();
      exp_w.delete();
      exp_b.delete();
      begin
         int exp_done;
         exp_done = 0;
         for (int r = 0; r < 40; r++) begin
            int lay, neu, n;
            bit last;
            lay  = $urandom_range(1, 4);
            neu  = $urandom_range(0, 29);
            n    = $urandom_range(1, 5);
            last = ($urandom_range(0, 3) == 0);
            if (last) exp_done++;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            put(hdr(last, lay, neu, n));
            for (int k = 0; k < n + (BIAS_EN ? 1 : 0); k++) begin
               logic [31:0] w;
               w = $urandom;
               if (k < n) exp_w.push_back({32'(lay), 32'(neu), w});
               else       exp_b.push_back({32'(lay), 32'(neu), w});
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
               put(w);
            end
         end
         idle(2);
         check("rnd_w_count", obs_w.size(), exp_w.size());
         check("rnd_b_count", obs_b.size(), exp_b.size());
         for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
            check("rnd_w_event", obs_w[i], exp_w[i]);
         for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
            check("rnd_b_event", obs_b[i], exp_b[i]);
         check("rnd_done_cnt", done_cnt, exp_done);
         check("rnd_rec_count", rec_count, 16'd40);
         check("rnd_err", err, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
